// File: rtl/ascon_pkg.sv
// Shared ASCON types and output-path width constants.
// Used by the bdo unpacker and the other ascon blocks.
package ascon_pkg;

    typedef enum logic [3:0] {
        D_NULL  = 4'd0,
        D_NONCE = 4'd1,
        D_AD    = 4'd2,
        D_MSG   = 4'd3,
        D_TAG   = 4'd4,
        D_HASH  = 4'd5
    } e_data_type;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } e_bdo_state;

    localparam int ASCON_CCW = 64;
    localparam int ASCON_OW  = 32;
    localparam int ASCON_NW  = 4;

    // Word count implied by a valid mask: position of the highest set bit plus one.
    function automatic logic [3:0] mask_to_count(input logic [7:0] mask);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) n = 4'(i + 1);
        end
        return n;
    endfunction

endpackage

// File: rtl/ascon_bdo_unpacker.sv
// Serializes 128-bit bdo blocks from ascon_core into 32-bit words with type/last side info.
// Optional handshake counter on word_cnt_o is enabled by defining ASCON_BDO_CNT_EN.
module ascon_bdo_unpacker
    import ascon_pkg::*;
#(
    parameter int CCW = ASCON_CCW,
    parameter int OW  = ASCON_OW
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [2*CCW-1:0]        bdo_i,
    input  logic [(2*CCW/OW)-1:0]   bdo_word_valid_i,
    input  logic                    bdo_valid_i,
    output logic                    bdo_ready_o,
    input  e_data_type              bdo_type_i,
    input  logic                    bdo_eot_i,
    output logic [OW-1:0]           word_o,
    output logic                    word_valid_o,
    input  logic                    word_ready_i,
    output e_data_type              word_type_o,
    output logic                    word_last_o,
    output logic                    busy_o
`ifdef ASCON_BDO_CNT_EN
    ,
    output logic [15:0]             word_cnt_o
`endif
);

    localparam int BW = 2 * CCW;
    localparam int NW = BW / OW;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    e_bdo_state     r_state;
    logic [BW-1:0]  r_buf;
    e_data_type     r_type;
    logic           r_eot;
    logic [IW-1:0]  r_idx;
    logic [IW-1:0]  r_last_idx;

    logic [3:0]     w_n;
    logic [3:0]     w_n_m1;
    logic           w_send;
    logic           w_final;
    logic           w_load;
    logic [OW-1:0]  w_words [NW];

    assign w_n     = mask_to_count(8'(bdo_word_valid_i));
    assign w_n_m1  = w_n - 4'd1;
    assign w_send  = (r_state == S_SEND);
    assign w_final = w_send && (r_idx == r_last_idx);

    // Ready in SEND only when the last word is leaving, so the next block reloads with no bubble.
    assign bdo_ready_o = !rst_i && !flush_i && ((r_state == S_IDLE) || (w_final && word_ready_i));
    assign w_load      = bdo_valid_i && bdo_ready_o;

    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_word_mux
            assign w_words[gi] = r_buf[gi*OW +: OW];
        end
    endgenerate

    assign word_o       = w_send ? w_words[r_idx] : '0;
    assign word_valid_o = w_send;
    assign word_type_o  = w_send ? r_type : D_NULL;
    assign word_last_o  = w_final && r_eot;
    assign busy_o       = w_send;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_type     <= D_NULL;
            r_eot      <= 1'b0;
            r_idx      <= '0;
            r_last_idx <= '0;
        end else if (flush_i) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_type     <= D_NULL;
            r_eot      <= 1'b0;
            r_idx      <= '0;
            r_last_idx <= '0;
        end else if (w_load) begin
            // An empty mask consumes the block without emitting anything.
            r_state    <= (w_n == 4'd0) ? S_IDLE : S_SEND;
            r_buf      <= bdo_i;
            r_type     <= bdo_type_i;
            r_eot      <= bdo_eot_i;
            r_idx      <= '0;
            r_last_idx <= w_n_m1[IW-1:0];
        end else if (w_send && word_ready_i) begin
            if (w_final) begin
                r_state <= S_IDLE;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

`ifdef ASCON_BDO_CNT_EN
    logic [15:0] r_word_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_word_cnt <= 16'd0;
        end else if (word_valid_o && word_ready_i) begin
            r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign word_cnt_o = r_word_cnt;
`endif

endmodule
